// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// multicycle_ctrl_fsm_if - instruction/data memory handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------
interface multicycle_ctrl_fsm_if;
  logic [31:0] instr;
  logic        imem_ready;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_req;
  logic        dmem_we;

  modport master (
    input  instr, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we
  );

  modport slave (
    output instr, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------
// multicycle_ctrl_fsm - FETCH/DECODE/EXEC/MEM/WB sequencer, RV32I subset
// Rev 1.0
// ----------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  wire                    clk,
  input  wire                    reset,
  multicycle_ctrl_fsm_if.master  mem,
  input  wire                    alu_zero,
  output logic                   ir_write,
  output logic                   alu_src,
  output logic [3:0]             alu_ctrl,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   pc_write,
  output logic                   pc_sel,
  output logic                   halted,
  output logic                   illegal_instr,
  output logic                   bus_error,
  output logic [2:0]             state,
  output logic [CNT_W-1:0]       retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_br    = 7'b1100011;

  localparam logic [3:0] c_alu_add = 4'b0000;
  localparam logic [3:0] c_alu_sub = 4'b0001;
  localparam logic [3:0] c_alu_and = 4'b0010;
  localparam logic [3:0] c_alu_or  = 4'b0011;
  localparam logic [3:0] c_alu_xor = 4'b0100;
  localparam logic [3:0] c_alu_slt = 4'b0101;
  localparam logic [3:0] c_alu_sll = 4'b0110;
  localparam logic [3:0] c_alu_srl = 4'b0111;

  localparam logic [7:0] c_wait_lim = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             bit30_q, bit30_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic       is_r, is_i, is_lw, is_sw, is_br, legal, retire;
  logic [3:0] alu_op;

  assign is_r  = (opcode_q == c_op_r);
  assign is_i  = (opcode_q == c_op_i);
  assign is_lw = (opcode_q == c_op_load);
  assign is_sw = (opcode_q == c_op_store);
  assign is_br = (opcode_q == c_op_br);

  // funct3=011 (SLTU) has no ALU encoding, so it is rejected for R/I
  assign legal = ((is_r || is_i) && (funct3_q != 3'b011)) ||
                 ((is_lw || is_sw) && (funct3_q == 3'b010)) ||
                 (is_br && (funct3_q[2:1] == 2'b00));

  always_comb begin
    alu_op = c_alu_add;
    case (funct3_q)
      3'b000:  alu_op = (is_r && bit30_q) ? c_alu_sub : c_alu_add;
      3'b001:  alu_op = c_alu_sll;
      3'b010:  alu_op = c_alu_slt;
      3'b100:  alu_op = c_alu_xor;
      3'b101:  alu_op = c_alu_srl;
      3'b110:  alu_op = c_alu_or;
      3'b111:  alu_op = c_alu_and;
      default: alu_op = c_alu_add;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct3_d     = funct3_q;
    bit30_d      = bit30_q;
    wait_d       = '0;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    retire       = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    alu_src      = 1'b0;
    alu_ctrl     = c_alu_add;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          opcode_d = mem.instr[6:0];
          funct3_d = mem.instr[14:12];
          bit30_d  = mem.instr[30];
          state_d  = S_DECODE;
        end else if (wait_q == c_wait_lim) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        alu_src  = is_i || is_lw || is_sw;
        alu_ctrl = is_br ? c_alu_sub : ((is_lw || is_sw) ? c_alu_add : alu_op);
        if (is_br) begin
          pc_write = 1'b1;
          pc_sel   = funct3_q[0] ? !alu_zero : alu_zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_sw;
        alu_src      = 1'b1;
        alu_ctrl     = c_alu_add;
        if (mem.dmem_ready) begin
          if (is_sw) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == c_wait_lim) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;

    // Control strobes are held low for the whole time reset is asserted
    if (!reset) begin
      mem.imem_req = 1'b0;
      mem.dmem_req = 1'b0;
      mem.dmem_we  = 1'b0;
      ir_write     = 1'b0;
      alu_src      = 1'b0;
      alu_ctrl     = c_alu_add;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      halted       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      opcode_q  <= '0;
      funct3_q  <= '0;
      bit30_q   <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      bit30_q   <= bit30_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state         = state_q;
  assign retired       = retired_q;
  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_multicycle_ctrl_fsm - cycle-by-cycle vector bench for the sequencer
// Rev 1.0
// ----------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ORI  = 32'h0050E193;
  localparam logic [31:0] I_ADDN = 32'hC0008193;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_LB   = 32'h00008183;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  // {imem_req, ir_write, dmem_req, dmem_we, alu_src, alu_ctrl[3:0],
  //  mem_to_reg, reg_write, pc_write, pc_sel, halted, illegal, bus_error}
  localparam logic [15:0] IREQ = 16'h8000, IRW = 16'h4000, DREQ = 16'h2000;
  localparam logic [15:0] DWE  = 16'h1000, ASRC = 16'h0800, M2R = 16'h0040;
  localparam logic [15:0] RW   = 16'h0020, PW = 16'h0010, PS = 16'h0008;
  localparam logic [15:0] HLT  = 16'h0004, ILL = 16'h0002, BER = 16'h0001;
  localparam logic [15:0] OP_SUB = 16'h0080, OP_OR = 16'h0180;

  typedef struct packed {
    logic        r;
    logic [31:0] instr;
    logic        ir;
    logic        dr;
    logic        z;
    logic [2:0]  st;
    logic [15:0] ctl;
    logic [31:0] ret;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        alu_zero;
  logic        ir_write, alu_src, mem_to_reg, reg_write, pc_write, pc_sel;
  logic        halted, illegal_instr, bus_error;
  logic [3:0]  alu_ctrl;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [15:0] ctl_act;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (bus),
    .alu_zero      (alu_zero),
    .ir_write      (ir_write),
    .alu_src       (alu_src),
    .alu_ctrl      (alu_ctrl),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .pc_write      (pc_write),
    .pc_sel        (pc_sel),
    .halted        (halted),
    .illegal_instr (illegal_instr),
    .bus_error     (bus_error),
    .state         (state),
    .retired       (retired)
  );

  assign ctl_act = {bus.imem_req, ir_write, bus.dmem_req, bus.dmem_we, alu_src,
                    alu_ctrl, mem_to_reg, reg_write, pc_write, pc_sel,
                    halted, illegal_instr, bus_error};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    ncyc   = 0;
  string phase  = "reset";
  vec_t  sb[$];
  vec_t  tbl[$];

  function automatic vec_t v(input logic r, input logic [31:0] instr,
                             input logic ir, input logic dr, input logic z,
                             input logic [2:0] st, input logic [15:0] ctl,
                             input logic [31:0] ret);
    vec_t t;
    t.r = r; t.instr = instr; t.ir = ir; t.dr = dr; t.z = z;
    t.st = st; t.ctl = ctl; t.ret = ret;
    return t;
  endfunction

  task automatic check_out();
    vec_t e;
    e = sb.pop_front();
    checks++;
    if (state !== e.st || ctl_act !== e.ctl || retired !== e.ret) begin
      errors++;
      $display("FAIL %s cyc%0d: got state=%0d ctl=%h retired=%0d, want state=%0d ctl=%h retired=%0d",
               phase, ncyc, state, ctl_act, retired, e.st, e.ctl, e.ret);
    end
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    reset          = t.r;
    bus.instr      = t.instr;
    bus.imem_ready = t.ir;
    bus.dmem_ready = t.dr;
    alu_zero       = t.z;
    sb.push_back(t);
    ncyc++;
    #2;
    check_out();
  endtask

  task automatic fetch_sw(input logic [31:0] ret);
    step(v(1, I_SW, 1, 0, 0, 3'd0, IREQ | IRW, ret));
    step(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, ret));
    step(v(1, 32'h0, 0, 0, 0, 3'd2, ASRC, ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    bus.instr      = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    alu_zero       = 1'b0;

    // reset, ADD, SUB with one fetch wait, ORI, ADDI with bit30 set
    tbl.push_back(v(0, I_ADD, 1, 0, 0, 3'd0, 16'h0, 0));
    tbl.push_back(v(1, I_ADD, 1, 0, 0, 3'd0, IREQ | IRW, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, 16'h0, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd4, RW | PW, 0));
    tbl.push_back(v(1, I_SUB, 0, 0, 0, 3'd0, IREQ, 1));
    tbl.push_back(v(1, I_SUB, 1, 0, 0, 3'd0, IREQ | IRW, 1));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 1));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, OP_SUB, 1));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd4, RW | PW, 1));
    tbl.push_back(v(1, I_ORI, 1, 0, 0, 3'd0, IREQ | IRW, 2));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 2));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, ASRC | OP_OR, 2));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd4, RW | PW, 2));
    tbl.push_back(v(1, I_ADDN, 1, 0, 0, 3'd0, IREQ | IRW, 3));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 3));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, ASRC, 3));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd4, RW | PW, 3));
    // LW with three data wait states
    tbl.push_back(v(1, I_LW, 1, 0, 0, 3'd0, IREQ | IRW, 4));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 4));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, ASRC, 4));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd3, DREQ | ASRC, 4));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd3, DREQ | ASRC, 4));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd3, DREQ | ASRC, 4));
    tbl.push_back(v(1, 32'h0, 0, 1, 0, 3'd3, DREQ | ASRC, 4));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd4, M2R | RW | PW, 4));
    // SW, zero wait
    tbl.push_back(v(1, I_SW, 1, 0, 0, 3'd0, IREQ | IRW, 5));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 5));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, ASRC, 5));
    tbl.push_back(v(1, 32'h0, 0, 1, 0, 3'd3, DREQ | DWE | ASRC | PW, 5));
    // branches
    tbl.push_back(v(1, I_BEQ, 1, 0, 0, 3'd0, IREQ | IRW, 6));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 6));
    tbl.push_back(v(1, 32'h0, 0, 0, 1, 3'd2, PW | PS | OP_SUB, 6));
    tbl.push_back(v(1, I_BEQ, 1, 0, 0, 3'd0, IREQ | IRW, 7));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 7));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, PW | OP_SUB, 7));
    tbl.push_back(v(1, I_BNE, 1, 0, 0, 3'd0, IREQ | IRW, 8));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 8));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd2, PW | PS | OP_SUB, 8));
    // LB (load with funct3=000) is unsupported
    tbl.push_back(v(1, I_LB, 1, 0, 0, 3'd0, IREQ | IRW, 9));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 9));
    tbl.push_back(v(1, I_ADD, 1, 1, 1, 3'd5, HLT | ILL, 9));
    tbl.push_back(v(1, I_ADD, 1, 1, 0, 3'd5, HLT | ILL, 9));
    tbl.push_back(v(0, I_ADD, 1, 1, 1, 3'd5, ILL, 9));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 3'd0, 16'h0, 0));
    // opcode 0x7F
    tbl.push_back(v(1, I_BAD, 1, 0, 0, 3'd0, IREQ | IRW, 0));
    tbl.push_back(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 0));
    tbl.push_back(v(1, I_SW, 1, 1, 1, 3'd5, HLT | ILL, 0));
    tbl.push_back(v(1, I_ADD, 1, 1, 0, 3'd5, HLT | ILL, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 3'd5, ILL, 0));
    tbl.push_back(v(0, 32'h0, 0, 0, 0, 3'd0, 16'h0, 0));

    phase = "table";
    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

    // SW with dmem_ready never arriving: 16 MEM cycles then HALT
    phase = "mem_timeout";
    fetch_sw(0);
    for (int k = 0; k < 16; k++) step(v(1, 32'h0, 0, 0, 0, 3'd3, DREQ | DWE | ASRC, 0));
    step(v(1, 32'h0, 0, 1, 0, 3'd5, HLT | BER, 0));
    step(v(1, 32'h0, 1, 1, 0, 3'd5, HLT | BER, 0));
    step(v(0, 32'h0, 0, 0, 0, 3'd5, BER, 0));
    step(v(0, 32'h0, 0, 0, 0, 3'd0, 16'h0, 0));

    // dmem_ready on the 16th MEM cycle wins
    phase = "mem_limit";
    fetch_sw(0);
    for (int k = 0; k < 15; k++) step(v(1, 32'h0, 0, 0, 0, 3'd3, DREQ | DWE | ASRC, 0));
    step(v(1, 32'h0, 0, 1, 0, 3'd3, DREQ | DWE | ASRC | PW, 0));
    step(v(1, 32'h0, 0, 0, 0, 3'd0, IREQ, 1));

    // reset during MEM of a SW aborts it
    phase = "reset_mid";
    fetch_sw(1);
    step(v(1, 32'h0, 0, 0, 0, 3'd3, DREQ | DWE | ASRC, 1));
    step(v(0, 32'h0, 0, 1, 0, 3'd3, 16'h0, 1));
    step(v(0, 32'h0, 0, 0, 0, 3'd0, 16'h0, 0));
    step(v(1, I_ADD, 1, 0, 0, 3'd0, IREQ | IRW, 0));
    step(v(1, 32'h0, 0, 0, 0, 3'd1, 16'h0, 0));
    step(v(1, 32'h0, 0, 0, 0, 3'd2, 16'h0, 0));
    step(v(1, 32'h0, 0, 0, 0, 3'd4, RW | PW, 0));

    // instruction fetch timeout
    phase = "fetch_timeout";
    for (int k = 0; k < 16; k++) step(v(1, 32'h0, 0, 0, 0, 3'd0, IREQ, 1));
    step(v(1, 32'h0, 0, 0, 0, 3'd5, HLT | BER, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
